// File: rtl/ad_cmos_tx_pkg.sv
// Shared types and constants for the AD CMOS transmit controller:
// FSM states, slot phase encoding and the tx_frame patterns.
package ad_cmos_tx_pkg;

  localparam int DW_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } tx_state_e;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } tx_phase_e;

  typedef struct packed {
    logic pos;
    logic neg;
  } frame_t;

  localparam frame_t FRAME_IDLE = '{pos: 1'b0, neg: 1'b0};
  localparam frame_t FRAME_1T   = '{pos: 1'b1, neg: 1'b0};
  localparam frame_t FRAME_2T_A = '{pos: 1'b1, neg: 1'b1};
  localparam frame_t FRAME_2T_B = '{pos: 1'b0, neg: 1'b0};

  // Frame pattern of an active cycle, given the channel mode and slot phase.
  function automatic frame_t frame_for(input logic two_t, input tx_phase_e ph);
    if (!two_t) return FRAME_1T;
    return (ph == PH_A) ? FRAME_2T_A : FRAME_2T_B;
  endfunction

endpackage

// File: rtl/ad_cmos_tx_slot_cnt.sv
// Slot phase tracker and LEAD/FLUSH slot counter. Reports the last cycle of
// the current slot and whether the current/next slot is the final counted one.
module ad_cmos_tx_slot_cnt
  import ad_cmos_tx_pkg::*;
#(
  parameter int LEAD_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      active_i,
  input  logic      mode_2t_i,
  input  logic      clr_i,
  output tx_phase_e phase_next_o,
  output logic      slot_last_o,
  output logic      cnt_tc_o,
  output logic      tc_next_o
);

  localparam logic [7:0] TC = 8'(LEAD_CYCLES - 1);

  tx_phase_e  phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       slot_last;

  assign slot_last = active_i && (!mode_2t_i || phase_q == PH_B);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_d = PH_A;
    cnt_d   = cnt_q;
    if (active_i && mode_2t_i && phase_q == PH_A) phase_d = PH_B;
    if (clr_i)                          cnt_d = '0;
    else if (slot_last && cnt_q != TC)  cnt_d = cnt_q + 8'd1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_A;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_next_o = phase_d;
  assign slot_last_o  = slot_last;
  assign cnt_tc_o     = (cnt_q == TC);
  assign tc_next_o    = (cnt_d == TC);

endmodule

// File: rtl/ad_cmos_tx_ctrl.sv
// Transmit-side controller for a CMOS DDR sample interface: sequences
// lead-in, sample streaming (1T/2T) and flush, with fully registered outputs.
module ad_cmos_tx_ctrl
  import ad_cmos_tx_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int LEAD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_en,
  input  logic            mode_2t,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [4*DW-1:0] s_data,
  output logic [DW-1:0]   d_pos,
  output logic [DW-1:0]   d_neg,
  output logic            frame_pos,
  output logic            frame_neg,
  output logic            busy,
  output logic            underflow,
  output logic [15:0]     underflow_cnt
);

  tx_state_e       state_q, state_d;
  logic            mode_q, mode_d;
  logic [2*DW-1:0] hold_q, hold_d;
  logic [DW-1:0]   d_pos_q, d_pos_d, d_neg_q, d_neg_d;
  frame_t          frame_q, frame_d;
  logic            s_ready_q, s_ready_d;
  logic            busy_q, ufl_q;
  logic [15:0]     ucnt_q, ucnt_d;

  tx_phase_e phase_next;
  logic      slot_last, cnt_tc, tc_next, active, cnt_clr, take, starve, last_next;

  assign active  = (state_q != ST_IDLE);
  assign take    = s_ready_q && s_valid;
  assign starve  = s_ready_q && !s_valid;
  assign cnt_clr = (state_q == ST_IDLE && tx_en) ||
                   (state_q == ST_RUN && slot_last && !s_ready_q);

  ad_cmos_tx_slot_cnt #(
    .LEAD_CYCLES (LEAD_CYCLES)
  ) u_slot_cnt (
    .clk          (clk),
    .rst          (rst),
    .active_i     (active),
    .mode_2t_i    (mode_q),
    .clr_i        (cnt_clr),
    .phase_next_o (phase_next),
    .slot_last_o  (slot_last),
    .cnt_tc_o     (cnt_tc),
    .tc_next_o    (tc_next)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ucnt_d  = ucnt_q;
    hold_d  = hold_q;
    d_pos_d = '0;
    d_neg_d = '0;

    case (state_q)
      ST_IDLE: if (tx_en) begin
        state_d = ST_LEAD;
        mode_d  = mode_2t;
        ucnt_d  = '0;
      end
      ST_LEAD:  if (slot_last && cnt_tc)     state_d = ST_RUN;
      ST_RUN:   if (slot_last && !s_ready_q) state_d = ST_FLUSH;
      ST_FLUSH: if (slot_last && cnt_tc)     state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (starve && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;

    // A new slot starts from the accepted word; phase B replays the held i1/q1.
    if (take) begin
      d_pos_d = s_data[DW-1:0];
      d_neg_d = s_data[2*DW-1:DW];
      hold_d  = s_data[4*DW-1:2*DW];
    end else if (starve) begin
      hold_d  = '0;
    end else if (state_q == ST_RUN && !slot_last) begin
      d_pos_d = hold_q[DW-1:0];
      d_neg_d = hold_q[2*DW-1:DW];
    end

    last_next = !mode_d || phase_next == PH_B;
    frame_d   = (state_d == ST_IDLE) ? FRAME_IDLE : frame_for(mode_d, phase_next);
    s_ready_d = last_next && ((state_d == ST_LEAD && tc_next) ||
                              (state_d == ST_RUN && tx_en));
  end

  // NOTE: the sample hold register is reset too, so no stale word can leak after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      hold_q    <= '0;
      d_pos_q   <= '0;
      d_neg_q   <= '0;
      frame_q   <= FRAME_IDLE;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      ufl_q     <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      hold_q    <= hold_d;
      d_pos_q   <= d_pos_d;
      d_neg_q   <= d_neg_d;
      frame_q   <= frame_d;
      s_ready_q <= s_ready_d;
      busy_q    <= (state_d != ST_IDLE);
      ufl_q     <= starve;
      ucnt_q    <= ucnt_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign d_pos         = d_pos_q;
  assign d_neg         = d_neg_q;
  assign frame_pos     = frame_q.pos;
  assign frame_neg     = frame_q.neg;
  assign busy          = busy_q;
  assign underflow     = ufl_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_ad_cmos_tx_ctrl.sv
// Self-checking bench for ad_cmos_tx_ctrl: a slot-level queue model predicts
// every output cycle; directed scenarios plus randomized traffic drive it.
module tb_ad_cmos_tx_ctrl;

  localparam int DW = 12;
  localparam int LC = 4;

  localparam int M_IDLE = 0, M_LEAD = 1, M_RUN = 2, M_FLUSH = 3;
  localparam int K_PLAIN = 0, K_LEAD_LAST = 1, K_DATA = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            tx_en;
  logic            mode_2t;
  logic            s_valid;
  logic            s_ready;
  logic [4*DW-1:0] s_data;
  logic [DW-1:0]   d_pos;
  logic [DW-1:0]   d_neg;
  logic            frame_pos;
  logic            frame_neg;
  logic            busy;
  logic            underflow;
  logic [15:0]     underflow_cnt;

  ad_cmos_tx_ctrl #(
    .DW          (DW),
    .LEAD_CYCLES (LC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_en         (tx_en),
    .mode_2t       (mode_2t),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .d_pos         (d_pos),
    .d_neg         (d_neg),
    .frame_pos     (frame_pos),
    .frame_neg     (frame_neg),
    .busy          (busy),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one expected record per output cycle, built a slot at a time.
  typedef struct {
    logic [DW-1:0] dp;
    logic [DW-1:0] dn;
    logic          fp;
    logic          fn;
    logic          rdy;
    logic          ufl;
  } cyc_t;

  cyc_t cur;
  cyc_t pend[$];
  int   m_mode, m_left, m_kind, m_ucnt;
  bit   m_2t;

  function automatic logic rdy_for(input int kind);
    return (kind == K_LEAD_LAST) || (kind == K_DATA && tx_en);
  endfunction

  task automatic set_idle();
    cur.dp = '0; cur.dn = '0; cur.fp = 1'b0; cur.fn = 1'b0; cur.rdy = 1'b0; cur.ufl = 1'b0;
  endtask

  task automatic start_slot(input logic [4*DW-1:0] w, input logic ufl, input int kind);
    cyc_t a, b;
    m_kind = kind;
    a.dp = w[DW-1:0];      a.dn = w[2*DW-1:DW];    a.fp = 1'b1; a.ufl = ufl;
    b.dp = w[3*DW-1:2*DW]; b.dn = w[4*DW-1:3*DW];  b.fp = 1'b0; b.fn = 1'b0;
    b.rdy = 1'b0; b.ufl = 1'b0;
    if (m_2t) begin
      a.fn = 1'b1; a.rdy = 1'b0;
      cur = a;
      pend.push_back(b);
    end else begin
      a.fn = 1'b0; a.rdy = rdy_for(kind);
      cur = a;
    end
  endtask

  task automatic start_zero();
    m_left--;
    start_slot('0, 1'b0, (m_mode == M_LEAD && m_left == 0) ? K_LEAD_LAST : K_PLAIN);
  endtask

  task automatic start_data();
    if (s_valid) start_slot(s_data, 1'b0, K_DATA);
    else begin
      if (m_ucnt < 65535) m_ucnt++;
      start_slot('0, 1'b1, K_DATA);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_2t = 1'b0; m_ucnt = 0; m_left = 0; m_kind = K_PLAIN;
    pend.delete();
    set_idle();
  endtask

  task automatic model_edge();
    if (pend.size() > 0) begin
      cur     = pend.pop_front();
      cur.rdy = rdy_for(m_kind);
    end else begin
      case (m_mode)
        M_IDLE: if (tx_en) begin
          m_mode = M_LEAD; m_2t = mode_2t; m_ucnt = 0; m_left = LC;
          start_zero();
        end else set_idle();
        M_LEAD: if (m_left > 0) start_zero();
                else begin m_mode = M_RUN; start_data(); end
        M_RUN:  if (cur.rdy) start_data();
                else begin m_mode = M_FLUSH; m_left = LC; start_zero(); end
        default: if (m_left > 0) start_zero();
                 else begin m_mode = M_IDLE; set_idle(); end
      endcase
    end
  endtask

  task automatic compare_all();
    check("d_pos",         32'(d_pos),         32'(cur.dp));
    check("d_neg",         32'(d_neg),         32'(cur.dn));
    check("frame_pos",     32'(frame_pos),     32'(cur.fp));
    check("frame_neg",     32'(frame_neg),     32'(cur.fn));
    check("s_ready",       32'(s_ready),       32'(cur.rdy));
    check("busy",          32'(busy),          32'(m_mode != M_IDLE));
    check("underflow",     32'(underflow),     32'(cur.ufl));
    check("underflow_cnt", 32'(underflow_cnt), 32'(m_ucnt));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1 compare_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1 model_reset();
    compare_all();
    tick();
    rst = 1'b0;
  endtask

  task automatic go_idle();
    tx_en = 1'b0;
    for (int i = 0; i < 400 && m_mode != M_IDLE; i++) tick();
    check("go_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic wait_phase_a();
    for (int i = 0; i < 4 && !(m_mode == M_RUN && pend.size() == 1); i++) tick();
  endtask

  function automatic logic [4*DW-1:0] rand_word();
    return (4*DW)'({$urandom(), $urandom()});
  endfunction

  logic [4*DW-1:0] w;

  initial begin
    rst = 1'b1; tx_en = 1'b0; mode_2t = 1'b0; s_valid = 1'b0; s_data = '0;
    model_reset();
    #1 compare_all();
    tick();
    rst = 1'b0;

    // 1T steady stream: four zero lead slots, then the word every cycle.
    mode_2t = 1'b0; s_valid = 1'b1; tx_en = 1'b1;
    s_data = {12'h000, 12'h000, 12'h456, 12'h123};
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) check("r035_lead_dpos", 32'(d_pos), 32'h0);
      if (i >= 5) begin
        check("r035_dpos",   32'(d_pos), 32'h123);
        check("r035_dneg",   32'(d_neg), 32'h456);
        check("r035_frames", 32'({frame_pos, frame_neg}), 32'b10);
      end
    end
    go_idle();

    // 2T steady stream: phase A i0/q0 frames 1/1, phase B i1/q1 frames 0/0.
    mode_2t = 1'b1; s_valid = 1'b1; tx_en = 1'b1;
    s_data = {12'h004, 12'h003, 12'h002, 12'h001};
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i >= 9 && (i % 2) == 1) begin
        check("r036_a_dpos",   32'(d_pos), 32'h001);
        check("r036_a_dneg",   32'(d_neg), 32'h002);
        check("r036_a_frames", 32'({frame_pos, frame_neg}), 32'b11);
        check("r036_a_ready",  32'(s_ready), 32'd0);
      end else if (i >= 9) begin
        check("r036_b_dpos",   32'(d_pos), 32'h003);
        check("r036_b_dneg",   32'(d_neg), 32'h004);
        check("r036_b_frames", 32'({frame_pos, frame_neg}), 32'b00);
        check("r036_b_ready",  32'(s_ready), 32'd1);
      end
    end
    go_idle();

    // 1T underflow: three starved slots, then mode_2t toggling is ignored.
    mode_2t = 1'b0; s_valid = 1'b1; tx_en = 1'b1; s_data = rand_word();
    repeat (6) tick();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r037_ufl",  32'(underflow), 32'd1);
      check("r037_zero", 32'(d_pos), 32'h0);
    end
    s_valid = 1'b1;
    tick();
    check("r037_ufl_end", 32'(underflow), 32'd0);
    check("r037_cnt",     32'(underflow_cnt), 32'd3);
    for (int i = 0; i < 10; i++) begin
      mode_2t = ~mode_2t; s_data = rand_word();
      tick();
      check("r040_frames", 32'({frame_pos, frame_neg}), 32'b10);
    end
    go_idle();

    // 2T stop requested in phase A: phase B completes, then 8 flush cycles.
    mode_2t = 1'b1; tx_en = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin s_data = rand_word(); tick(); end
    wait_phase_a();
    check("r038_phase_a", 32'({frame_pos, frame_neg}), 32'b11);
    tx_en = 1'b0;
    tick();
    check("r038_b_ready",  32'(s_ready), 32'd0);
    check("r038_b_frames", 32'({frame_pos, frame_neg}), 32'b00);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("r038_flush_busy", 32'(busy), 32'd1);
      check("r038_flush_dpos", 32'(d_pos), 32'h0);
    end
    tick();
    check("r038_idle_busy", 32'(busy), 32'd0);

    // Reset mid-RUN in phase A, then a full restart with lead-in.
    mode_2t = 1'b1; tx_en = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin s_data = rand_word(); tick(); end
    wait_phase_a();
    apply_reset();
    check("r039_busy", 32'(busy), 32'd0);
    check("r039_dpos", 32'(d_pos), 32'h0);
    mode_2t = 1'b0; tx_en = 1'b1; w = rand_word(); s_data = w;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i <= 4) check("r039_lead_dpos", 32'(d_pos), 32'h0);
      else        check("r039_first_dpos", 32'(d_pos), 32'(w[DW-1:0]));
    end

    // Randomized traffic with occasional stops, mode changes and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) tx_en = ~tx_en;
      mode_2t = 1'($urandom_range(0, 1));
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = rand_word();
      if ($urandom_range(0, 399) == 0) apply_reset();
      else tick();
    end
    go_idle();

    // Underflow counter saturation, then cleared on the next start.
    mode_2t = 1'b0; s_valid = 1'b0; tx_en = 1'b1;
    for (int i = 0; i < 65545; i++) tick();
    check("r037_sat_cnt", 32'(underflow_cnt), 32'hFFFF);
    tick();
    check("r037_sat_hold", 32'(underflow_cnt), 32'hFFFF);
    check("r037_sat_ufl",  32'(underflow), 32'd1);
    go_idle();
    tx_en = 1'b1;
    tick();
    check("cnt_cleared", 32'(underflow_cnt), 32'd0);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
